i2c_byte_master: RTL and testbench

- Downstream I2C master engine for the DAC configuration path.
- Buffers bytes pushed by the register-side wrapper in a small FIFO.
- On a start pulse it emits one complete I2C write transaction: START, every queued byte MSB-first with an ACK check after each, then STOP.
- Drives scl and an open-drain-style sda_out (1 = release), and reads sda_in back from the pad buffer.

---
 rtl/i2c_byte_master.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// i2c_byte_master
// Byte-FIFO-fed I2C write engine: START, each byte MSB-first + ACK, STOP.
// Revision: 1.0
// ============================================================================
module i2c_byte_master #(
  parameter int I2C_CLOCK_DIVIDER = 1000,
  parameter int FIFO_LENGTH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     fifo_in,
  input  logic                           rdy,
  input  logic                           start,
  input  logic                           sda_in,
  output logic                           sda_out,
  output logic                           scl,
  output logic                           busy,
  output logic                           ended,
  output logic                           ack,
  output logic                           fifo_full,
  output logic [$clog2(FIFO_LENGTH):0]   fifo_count
);

  localparam int QUARTER = I2C_CLOCK_DIVIDER / 4;
  localparam int QTR_W   = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int PTR_W   = $clog2(FIFO_LENGTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START_A = 4'd1,
    S_START_B = 4'd2,
    S_BIT     = 4'd3,
    S_ACK     = 4'd4,
    S_STOP_A  = 4'd5,
    S_STOP_B  = 4'd6,
    S_STOP_C  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [QTR_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [1:0]         quarter_q, quarter_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               nack_q, nack_d;
  logic               ack_q, ack_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_LENGTH];

  logic tick;
  logic pop;
  logic flush;
  logic push;
  logic active;

  assign active = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tick   = (tick_cnt_q == QTR_W'(QUARTER - 1));
  // A flush on NACK takes priority over a simultaneous push.
  assign push   = rdy && (count_q != CNT_W'(FIFO_LENGTH)) && !flush;

  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    nack_d    = nack_q;
    ack_d     = ack_q;
    pop       = 1'b0;
    flush     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (count_q != '0)) begin
          state_d = S_START_A;
          nack_d  = 1'b0;
        end
      end
      S_START_A: begin
        if (tick) begin
          state_d   = S_START_B;
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = 3'd7;
          quarter_d = 2'd0;
        end
      end
      S_START_B: begin
        if (tick) state_d = S_BIT;
      end
      S_BIT: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_idx_q == 3'd0) state_d = S_ACK;
            else                   bit_idx_d = bit_idx_q - 3'd1;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd2) nack_d = sda_in;
          if (quarter_q == 2'd3) begin
            if (nack_q) begin
              state_d = S_STOP_A;
              flush   = 1'b1;
            end else if (count_q != '0) begin
              state_d   = S_BIT;
              pop       = 1'b1;
              shift_d   = mem_q[rd_ptr_q];
              bit_idx_d = 3'd7;
            end else begin
              state_d = S_STOP_A;
            end
          end
        end
      end
      S_STOP_A: if (tick) state_d = S_STOP_B;
      S_STOP_B: if (tick) state_d = S_STOP_C;
      S_STOP_C: begin
        if (tick) begin
          state_d = S_DONE;
          ack_d   = ~nack_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d = '0;
    if (active && !tick) tick_cnt_d = tick_cnt_q + QTR_W'(1);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    scl     = 1'b1;
    sda_out = 1'b1;
    case (state_q)
      S_START_A: sda_out = 1'b0;
      S_START_B: begin scl = 1'b0; sda_out = 1'b0; end
      S_BIT:     begin scl = quarter_q[1]; sda_out = shift_q[7]; end
      S_ACK:     scl = quarter_q[1];
      S_STOP_A:  begin scl = 1'b0; sda_out = 1'b0; end
      S_STOP_B:  sda_out = 1'b0;
      default:   ;
    endcase
  end

  assign busy       = active;
  assign ended      = (state_q == S_DONE);
  assign ack        = ack_q;
  assign fifo_full  = (count_q == CNT_W'(FIFO_LENGTH));
  assign fifo_count = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      quarter_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      nack_q     <= 1'b0;
      ack_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      quarter_q  <= quarter_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      nack_q     <= nack_d;
      ack_q      <= ack_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fifo_in;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_i2c_byte_master
// Directed plus randomized bench for i2c_byte_master with a transaction model.
// Revision: 1.0
// ============================================================================
module tb_i2c_byte_master;

  localparam int DIV = 16;
  localparam int Q   = DIV / 4;
  localparam int L   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] fifo_in = 8'h00;
  logic       rdy = 1'b0;
  logic       start = 1'b0;
  logic       sda_in;
  logic       sda_out, scl, busy, ended, ack, fifo_full;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  i2c_byte_master #(.I2C_CLOCK_DIVIDER(DIV), .FIFO_LENGTH(L)) dut (
    .clk(clk), .rst(rst), .fifo_in(fifo_in), .rdy(rdy), .start(start),
    .sda_in(sda_in), .sda_out(sda_out), .scl(scl), .busy(busy),
    .ended(ended), .ack(ack), .fifo_full(fifo_full), .fifo_count(fifo_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // sda_in source: 0 = always ACK, 1 = always NACK, 2 = random with rare NACK
  int sda_mode = 0;
  always @(negedge clk) begin
    case (sda_mode)
      0:       sda_in <= 1'b0;
      1:       sda_in <= 1'b1;
      default: sda_in <= ($urandom_range(0, 7) == 0);
    endcase
  end

  // Transaction model: position in the transaction is derived from elapsed cycles.
  logic [7:0] m_fifo[$];
  logic [7:0] m_sent[$];
  bit         m_busy, m_done, m_ack, m_nack, m_flush, m_end;
  int         m_t, m_pre, m_k, m_r, m_nb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_fifo.delete(); m_sent.delete();
      m_busy = 0; m_done = 0; m_ack = 0; m_nack = 0; m_t = 0;
    end else begin
      m_pre = m_fifo.size(); m_flush = 0; m_end = 0;
      if (m_done) begin
        m_done = 0;
      end else if (!m_busy) begin
        if (start && m_pre > 0) begin
          m_busy = 1; m_t = 0; m_nack = 0; m_sent.delete();
        end
      end else begin
        m_k = m_t / Q; m_r = m_t % Q; m_nb = m_sent.size();
        if (m_r == Q - 1) begin
          if (m_k == 0) m_sent.push_back(m_fifo.pop_front());
          else if (m_k == 36 * m_nb) m_nack = sda_in;
          else if (m_k == 36 * m_nb + 1) begin
            if (m_nack) m_flush = 1;
            else if (m_fifo.size() > 0) m_sent.push_back(m_fifo.pop_front());
          end
        end
        if (m_t == (5 + 36 * m_nb) * Q - 1) m_end = 1;
        m_t++;
        if (m_end) begin m_busy = 0; m_done = 1; m_ack = !m_nack; end
      end
      if (m_flush) m_fifo.delete();
      else if (rdy && m_pre < L) m_fifo.push_back(fifo_in);
    end
  end

  task automatic exp_bus(output bit e_scl, output bit e_sda);
    int k, nb, j, bi, s;
    logic [7:0] b;
    e_scl = 1; e_sda = 1;
    if (m_busy) begin
      k = m_t / Q; nb = m_sent.size();
      if (k == 0) e_sda = 0;
      else if (k == 1) begin e_scl = 0; e_sda = 0; end
      else if (k < 2 + 36 * nb) begin
        j = (k - 2) % 36; bi = j / 4;
        e_scl = ((j % 4) >= 2);
        b = m_sent[(k - 2) / 36];
        e_sda = (bi < 8) ? b[7 - bi] : 1'b1;
      end else begin
        s = k - (2 + 36 * nb);
        e_scl = (s != 0); e_sda = (s == 2);
      end
    end
  endtask

  always @(negedge clk) begin
    bit es, ed;
    if (rst) begin
      exp_bus(es, ed);
      chk("scl", scl, es);
      chk("sda_out", sda_out, ed);
      chk("busy", busy, m_busy);
      chk("ended", ended, m_done);
      chk("ack", ack, m_ack);
      chk("fifo_count", fifo_count, m_fifo.size());
      chk("fifo_full", fifo_full, m_fifo.size() == L);
    end
  end

  // Completed SCL pulses and the SDA level held while each was high.
  int          pulses = 0;
  logic [63:0] bits = '0;
  bit          prev_scl = 1, rose = 0, hi_sda = 1;
  always @(negedge clk) begin
    if (!busy) rose = 0;
    else if (!prev_scl && scl) rose = 1;
    if (scl) hi_sda = sda_out;
    if (prev_scl && !scl && rose) begin
      pulses++; bits = {bits[62:0], hi_sda}; rose = 0;
    end
    prev_scl = scl;
  end

  task automatic push(input logic [7:0] b);
    rdy = 1; fifo_in = b;
    @(negedge clk);
    rdy = 0;
  endtask

  task automatic run_txn(input int push_at, input logic [7:0] pb, input int start_at,
                         output int cyc);
    start = 1;
    @(negedge clk);
    start = 0; cyc = 1;
    while (!ended && cyc < 3000) begin
      rdy = (cyc == push_at); fifo_in = pb; start = (cyc == start_at);
      @(negedge clk);
      cyc++;
    end
    rdy = 0; start = 0;
    chk("txn_completed", ended, 1);
  endtask

  int cyc, p0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1); chk("rst_sda", sda_out, 1); chk("rst_busy", busy, 0);
    chk("rst_ended", ended, 0); chk("rst_ack", ack, 0); chk("rst_count", fifo_count, 0);
    #2 rst = 1;
    @(negedge clk);

    // Two bytes, all ACKed
    sda_mode = 0;
    push(8'h98); push(8'h12);
    p0 = pulses;
    run_txn(-1, 8'h00, -1, cyc);
    chk("ack_end_cycle", cyc, 309);
    chk("ack_flag", ack, 1);
    chk("ack_count", fifo_count, 0);
    chk("ack_pulses", pulses - p0, 18);
    chk("ack_bits", bits[17:0], {8'h98, 1'b1, 8'h12, 1'b1});

    // NACK on the first byte flushes the rest
    sda_mode = 1;
    push(8'h98); push(8'h12);
    p0 = pulses;
    run_txn(-1, 8'h00, -1, cyc);
    chk("nack_end_cycle", cyc, 165);
    chk("nack_flag", ack, 0);
    chk("nack_count", fifo_count, 0);
    chk("nack_pulses", pulses - p0, 9);
    chk("nack_bits", bits[8:0], {8'h98, 1'b1});

    // Overfill: fifth byte dropped
    sda_mode = 0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("full_flag", fifo_full, 1);
    chk("full_count", fifo_count, 4);
    p0 = pulses;
    run_txn(-1, 8'h00, -1, cyc);
    chk("full_end_cycle", cyc, 597);
    chk("full_pulses", pulses - p0, 36);
    chk("full_bits", bits[35:0],
        {8'h01, 1'b1, 8'h02, 1'b1, 8'h03, 1'b1, 8'h04, 1'b1});
    chk("full_ack", ack, 1);

    // start with empty FIFO is ignored
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 8; i++) begin
      chk("empty_busy", busy, 0); chk("empty_scl", scl, 1);
      @(negedge clk);
    end

    // Late push joins, mid-transaction start ignored
    push(8'hAA);
    p0 = pulses;
    run_txn(20, 8'h55, 50, cyc);
    chk("late_end_cycle", cyc, 309);
    chk("late_pulses", pulses - p0, 18);
    chk("late_bits", bits[17:0], {8'hAA, 1'b1, 8'h55, 1'b1});
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("late_single_txn", busy, 0);

    // Asynchronous reset mid-byte
    push(8'h3C); push(8'hC3);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk);
    #1 rst = 0;
    #1;
    chk("arst_scl", scl, 1); chk("arst_sda", sda_out, 1);
    chk("arst_busy", busy, 0); chk("arst_count", fifo_count, 0);
    @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    push(8'h5A);
    p0 = pulses;
    run_txn(-1, 8'h00, -1, cyc);
    chk("post_rst_end_cycle", cyc, 165);
    chk("post_rst_ack", ack, 1);
    chk("post_rst_bits", bits[8:0], {8'h5A, 1'b1});

    // Randomized traffic against the model
    sda_mode = 2;
    for (int i = 0; i < 6000; i++) begin
      rdy = ($urandom_range(0, 3) == 0);
      fifo_in = 8'($urandom);
      start = ($urandom_range(0, 30) == 0);
      @(negedge clk);
    end
    rdy = 0; start = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
